transpose_ctrl: RTL and testbench
=================================

Name: transpose_ctrl

Overview:
- Transpose-buffer controller between the row-pass and column-pass 1D DCT stages of the 8x8 2D DCT.
- Accepts 64 row-DCT coefficients in row-major order and writes them into the 64x16 single-port RAM.
- Reads them back column-major and streams them to the column-pass DCT with a valid/ready handshake.
- Single buffer: fill and drain never overlap.

Parameters:
- DATA_W, 16, coefficient width; must match the RAM word width.
- N, 8, block dimension; the RAM address width is fixed at 6 (N*N = 64).

Ports:
- clk  input  1  clock; all state updates on posedge.
- rst  input  1  synchronous reset, active-high.
- in_valid  input  1  upstream coefficient valid.
- in_ready  output  1  high while in FILL.
- in_data  input  DATA_W  row-DCT coefficient, row-major order.
- out_valid  output  1  out_data valid.
- out_ready  input  1  downstream accepts.
- out_data  output  DATA_W  coefficient, column-major order.
- out_last  output  1  high with the 64th output of a block.
- ram_address  output  6  RAM address.
- ram_data_in  output  DATA_W  RAM write data; equals in_data.
- ram_write  output  1  RAM write strobe.
- ram_read  output  1  RAM read strobe.
- ram_cs  output  1  RAM chip select.
- ram_data_out  input  DATA_W  RAM read data.

Behaviour:
- Clock is clk; reset is synchronous and active-high.
- States are FILL and DRAIN. Reset and power-up state is FILL.
- Counters: wr_cnt[6:0], rd_iss[6:0] (reads issued), rd_done[6:0] (outputs consumed). All clear on reset.
- Reset values: out_valid=0, out_last=0, out_data=0, in_ready=0 during reset. Combinational ram_* outputs are forced to 0 while rst=1. RAM contents are not cleared.

FILL:
- in_ready=1.
- On in_valid, drive combinationally: ram_cs=1, ram_write=1, ram_read=0, ram_address=wr_cnt[5:0]. The RAM captures on the negedge of the same cycle.
- wr_cnt increments on each accepted word.
- When the 64th word is accepted (wr_cnt==63 && in_valid), go to DRAIN next cycle and clear wr_cnt.
- When in_valid=0: ram_cs=0, ram_write=0, ram_read=0.

DRAIN:
- in_ready=0. in_valid is ignored and does not count as an error.
- Read issue condition: issue = (rd_iss<64) && (!out_valid || out_ready).
- On issue: ram_cs=1, ram_read=1, ram_write=0, ram_address={rd_iss[2:0], rd_iss[5:3]}. This is the transpose: element (row=rd_iss%8, col=rd_iss/8).
- Read latency is 1 cycle. The RAM updates ram_data_out on the negedge, and out_data<=ram_data_out is captured on the next posedge with out_valid<=1.
- out_last<=1 when the captured word is the one issued with rd_iss==63.
- On out_valid && out_ready with no capture in the same cycle: out_valid<=0, out_last<=0.
- A capture and a consume in the same cycle keep out_valid=1. This gives a sustained throughput of 1 word per cycle.
- out_data and out_last are held stable while out_valid && !out_ready.
- rd_done increments on each consume. When the consume with out_last occurs, go to FILL next cycle and clear rd_iss and rd_done.
- When no issue occurs: ram_cs=0, so RAM output floats. out_data is registered and therefore unaffected.

Boundary conditions:
- Reset mid-FILL or mid-DRAIN discards the partial block. The block restarts in FILL with wr_cnt=0 and out_valid=0.
- out_ready held low indefinitely during DRAIN stalls issue; no reads are lost.
- The first FILL word following a DRAIN is accepted in the cycle right after the final consume.

Optional Feature:
- Macro: TRANSPOSE_BLKCNT_EN.
- When defined, the block adds output blk_count[15:0].
- blk_count resets to 0 and increments by 1 on each consume with out_last; it wraps from 65535 to 0.
- When not defined, the port and counter are absent. All other behaviour is identical.

Test Plan:
- Reset then basic transpose: feed in_data = 0..63 continuously with out_ready=1. Required: out_data sequence is 0,8,16,...,56,1,9,...,63; out_last only on value 63; out_valid first rises 1 cycle after the first DRAIN issue.
- Backpressure: during DRAIN, toggle out_ready 1,0,0,1 repeatedly. Required: no duplicated or skipped words; out_data held while stalled; exactly 64 outputs.
- Input gaps: in_valid duty 50%. Required: exactly 64 writes, ram_write=0 on idle cycles, in_ready falls after the 64th write.
- DRAIN lockout: hold in_valid=1 with in_data=16'hFFFF throughout DRAIN. Required: in_ready=0, ram_write never asserted, output block unaffected.
- Reset mid-DRAIN after 20 outputs. Required: out_valid=0 the next cycle, state FILL, a new 64-word block transposes correctly.
- TRANSPOSE_BLKCNT_EN: run 3 back-to-back blocks. Required: blk_count = 1, 2, 3 after each out_last consume.

Source files
------------

// File: rtl/transpose_ctrl.sv
// Transpose buffer: 64 row-major coefficients in, the same 64 out column-major, one single-port RAM.
// Latency: first out_valid 2 cycles after the 64th write; drain sustains 1 word/cycle.
// Backpressure: out_ready low stalls read issue and holds out_data/out_last; in_ready is low in DRAIN.
// Build option: define TRANSPOSE_BLKCNT_EN to add blk_count (completed blocks, wraps at 16 bits).
module transpose_ctrl #(
   parameter int DATA_W = 16,
   parameter int N      = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic              out_last,
   output logic [5:0]        ram_address,
   output logic [DATA_W-1:0] ram_data_in,
   output logic              ram_write,
   output logic              ram_read,
   output logic              ram_cs,
   input  logic [DATA_W-1:0] ram_data_out
`ifdef TRANSPOSE_BLKCNT_EN
   ,
   output logic [15:0]       blk_count
`endif
);

   localparam int DEPTH = N * N;

   typedef enum logic {
      ST_FILL  = 1'b0,
      ST_DRAIN = 1'b1
   } state_t;

   state_t            state_q, state_d;
   logic [6:0]        wr_cnt_q, wr_cnt_d;
   logic [6:0]        rd_iss_q, rd_iss_d;
   logic [6:0]        rd_done_q, rd_done_d;
   logic              out_valid_q, out_valid_d;
   logic              out_last_q, out_last_d;
   logic [DATA_W-1:0] out_data_q, out_data_d;
   logic              issue;
   logic              consume;
`ifdef TRANSPOSE_BLKCNT_EN
   logic [15:0]       blk_count_q, blk_count_d;
`endif

   // Next-state, RAM strobes and handshake outputs; RAM-facing outputs are gated off during reset.
   always_comb begin
      state_d     = state_q;
      wr_cnt_d    = wr_cnt_q;
      rd_iss_d    = rd_iss_q;
      rd_done_d   = rd_done_q;
      out_valid_d = out_valid_q;
      out_last_d  = out_last_q;
      out_data_d  = out_data_q;
      in_ready    = 1'b0;
      ram_cs      = 1'b0;
      ram_write   = 1'b0;
      ram_read    = 1'b0;
      ram_address = 6'd0;
      ram_data_in = in_data;
      issue       = 1'b0;
      consume     = out_valid_q && out_ready;
`ifdef TRANSPOSE_BLKCNT_EN
      blk_count_d = blk_count_q;
`endif

      case (state_q)
         ST_FILL: begin
            in_ready = 1'b1;
            if (in_valid) begin
               ram_cs      = 1'b1;
               ram_write   = 1'b1;
               ram_address = wr_cnt_q[5:0];
               if (wr_cnt_q == 7'(DEPTH - 1)) begin
                  wr_cnt_d = 7'd0;
                  state_d  = ST_DRAIN;
               end else begin
                  wr_cnt_d = wr_cnt_q + 7'd1;
               end
            end
         end
         ST_DRAIN: begin
            // A new read may issue whenever the output register is empty or being emptied.
            issue = (rd_iss_q < 7'(DEPTH)) && (!out_valid_q || out_ready);
            if (issue) begin
               ram_cs      = 1'b1;
               ram_read    = 1'b1;
               // Swapping the row/column halves of the index walks the block column-major.
               ram_address = {rd_iss_q[2:0], rd_iss_q[5:3]};
               rd_iss_d    = rd_iss_q + 7'd1;
               // RAM presents data on the negedge, so it is captured at the end of the issue cycle.
               out_data_d  = ram_data_out;
               out_valid_d = 1'b1;
               out_last_d  = (rd_iss_q == 7'(DEPTH - 1));
            end else if (consume) begin
               out_valid_d = 1'b0;
               out_last_d  = 1'b0;
            end
            if (consume) begin
               rd_done_d = rd_done_q + 7'd1;
               if (out_last_q) begin
                  state_d   = ST_FILL;
                  rd_iss_d  = 7'd0;
                  rd_done_d = 7'd0;
`ifdef TRANSPOSE_BLKCNT_EN
                  blk_count_d = blk_count_q + 16'd1;
`endif
               end
            end
         end
         default: state_d = ST_FILL;
      endcase

      if (rst) begin
         in_ready    = 1'b0;
         ram_cs      = 1'b0;
         ram_write   = 1'b0;
         ram_read    = 1'b0;
         ram_address = 6'd0;
         ram_data_in = '0;
      end
   end

   // State and counter registers with synchronous reset; a reset discards any partial block.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_FILL;
         wr_cnt_q    <= 7'd0;
         rd_iss_q    <= 7'd0;
         rd_done_q   <= 7'd0;
         out_valid_q <= 1'b0;
         out_last_q  <= 1'b0;
         out_data_q  <= '0;
`ifdef TRANSPOSE_BLKCNT_EN
         blk_count_q <= 16'd0;
`endif
      end else begin
         state_q     <= state_d;
         wr_cnt_q    <= wr_cnt_d;
         rd_iss_q    <= rd_iss_d;
         rd_done_q   <= rd_done_d;
         out_valid_q <= out_valid_d;
         out_last_q  <= out_last_d;
         out_data_q  <= out_data_d;
`ifdef TRANSPOSE_BLKCNT_EN
         blk_count_q <= blk_count_d;
`endif
      end
   end

   assign out_valid = out_valid_q;
   assign out_last  = out_last_q;
   assign out_data  = out_data_q;
`ifdef TRANSPOSE_BLKCNT_EN
   assign blk_count = blk_count_q;
`endif

endmodule

// File: tb/tb_transpose_ctrl.sv
// Bench for transpose_ctrl: random traffic against a block-level transpose model and a negedge RAM.
// Inputs are driven 1 time unit after posedge; all DUT outputs are sampled on the negedge.
// Optional blk_count checking follows TRANSPOSE_BLKCNT_EN.
module tb_transpose_ctrl;

   logic        clk;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [15:0] in_data;
   logic        out_valid;
   logic        out_ready;
   logic [15:0] out_data;
   logic        out_last;
   logic [5:0]  ram_address;
   logic [15:0] ram_data_in;
   logic        ram_write;
   logic        ram_read;
   logic        ram_cs;
   logic [15:0] ram_data_out;
`ifdef TRANSPOSE_BLKCNT_EN
   logic [15:0] blk_count;
`endif

   transpose_ctrl #(.DATA_W(16), .N(8)) dut (
      .clk          (clk),
      .rst          (rst),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .in_data      (in_data),
      .out_valid    (out_valid),
      .out_ready    (out_ready),
      .out_data     (out_data),
      .out_last     (out_last),
      .ram_address  (ram_address),
      .ram_data_in  (ram_data_in),
      .ram_write    (ram_write),
      .ram_read     (ram_read),
      .ram_cs       (ram_cs),
      .ram_data_out (ram_data_out)
`ifdef TRANSPOSE_BLKCNT_EN
      ,
      .blk_count    (blk_count)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // 64x16 single-port RAM: writes and reads act on the negedge; unselected output is junk.
   logic [15:0] mem [64];
   always @(negedge clk) begin
      if (ram_cs && ram_write) mem[ram_address] <= ram_data_in;
      if (ram_cs && ram_read) ram_data_out <= mem[ram_address];
      else                    ram_data_out <= 16'($urandom);
   end

   int n_cmp = 0;
   int n_err = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Reference model state: words of the block being filled, expected output order.
   logic [15:0] in_q[$];
   logic [15:0] exp_q[$];
   bit          mdl_fill    = 1'b1;
   int          out_cnt_m   = 0;
   int          blocks_done = 0;
   int          mdl_blk     = 0;
   bit          rst_prev    = 1'b0;
   bit          stall_prev  = 1'b0;
   logic [15:0] held_data;
   logic        held_last;
   bit          lat_arm     = 1'b0;
   int          lat_cnt     = 0;

   // Stimulus modes set by the phase sequencer.
   int seq_mode  = 1;
   int iv_mode   = 0;    // 0 always valid, 1 random 50%
   int rdy_mode  = 0;    // 0 always ready, 1 pattern 1,0,0,1, 2 random
   int lock_mode = 0;    // hold in_valid=1 with 16'hFFFF while draining
   int ph        = 0;

   // Monitor and scoreboard.
   always @(negedge clk) begin
      logic [15:0] e;
`ifdef TRANSPOSE_BLKCNT_EN
      if (rst_prev) chk("blk_count_rst", blk_count, 0);
      else          chk("blk_count", blk_count, mdl_blk);
`endif
      if (rst) begin
         chk("rst_in_ready", in_ready, 0);
         chk("rst_ram_strobes", {ram_cs, ram_write, ram_read}, 0);
         if (rst_prev) begin
            chk("rst_out_valid", out_valid, 0);
            chk("rst_out_last", out_last, 0);
            chk("rst_out_data", out_data, 0);
         end
         in_q.delete();
         exp_q.delete();
         mdl_fill   = 1'b1;
         out_cnt_m  = 0;
         mdl_blk    = 0;
         lat_arm    = 1'b0;
         stall_prev = 1'b0;
      end else begin
         if (rst_prev) chk("post_rst_out_valid", out_valid, 0);
         if (stall_prev) begin
            chk("hold_valid", out_valid, 1);
            chk("hold_data", out_data, held_data);
            chk("hold_last", out_last, held_last);
         end
         if (lat_arm) begin
            lat_cnt++;
            if (lat_cnt == 1) chk("early_out_valid", out_valid, 0);
            else begin
               chk("first_valid_latency", out_valid, 1);
               lat_arm = 1'b0;
            end
         end
         chk("in_ready", in_ready, mdl_fill);
         chk("ram_write", ram_write, mdl_fill && in_valid);
         if (mdl_fill) begin
            chk("out_valid_in_fill", out_valid, 0);
            chk("ram_read_in_fill", ram_read, 0);
            chk("ram_cs_in_fill", ram_cs, in_valid);
            if (in_valid) begin
               chk("wr_address", ram_address, in_q.size());
               chk("wr_data", ram_data_in, in_data);
               in_q.push_back(in_data);
               if (in_q.size() == 64) begin
                  for (int c = 0; c < 8; c++)
                     for (int r = 0; r < 8; r++)
                        exp_q.push_back(in_q[r*8 + c]);
                  in_q.delete();
                  mdl_fill = 1'b0;
                  lat_arm  = 1'b1;
                  lat_cnt  = 0;
               end
            end
         end else if (out_valid && out_ready) begin
            chk("output_pending", exp_q.size() != 0, 1);
            if (exp_q.size() != 0) begin
               e = exp_q.pop_front();
               chk("out_data", out_data, e);
            end
            chk("out_last", out_last, out_cnt_m == 63);
            out_cnt_m++;
            if (out_cnt_m == 64) begin
               mdl_fill  = 1'b1;
               out_cnt_m = 0;
               blocks_done++;
               mdl_blk = (mdl_blk + 1) % 65536;
            end
         end
         stall_prev = out_valid && !out_ready;
         held_data  = out_data;
         held_last  = out_last;
      end
      rst_prev = rst;
   end

   // Input driver: changes stimulus 1 unit after each posedge.
   always @(posedge clk) begin
      bit pat [4];
      #1;
      pat = '{1'b1, 1'b0, 1'b0, 1'b1};
      ph++;
      if (lock_mode != 0 && !mdl_fill) begin
         in_valid = 1'b1;
         in_data  = 16'hFFFF;
      end else begin
         in_valid = (iv_mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
         in_data  = (seq_mode != 0) ? 16'(in_q.size()) : 16'($urandom);
      end
      case (rdy_mode)
         0:       out_ready = 1'b1;
         1:       out_ready = pat[ph % 4];
         default: out_ready = 1'($urandom_range(0, 1));
      endcase
   end

   task automatic run_blocks(input int n);
      int target;
      target = blocks_done + n;
      for (int cyc = 0; cyc < n * 1000; cyc++) begin
         @(negedge clk);
         if (blocks_done >= target) break;
      end
      chk("blocks_completed", blocks_done, target);
   endtask

   task automatic do_reset(input int cycles);
      @(posedge clk);
      #1 rst = 1'b1;
      repeat (cycles) @(posedge clk);
      #1 rst = 1'b0;
   endtask

   initial begin
      rst       = 1'b1;
      in_valid  = 1'b0;
      in_data   = 16'd0;
      out_ready = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;

      // Basic transpose of 0..63, no stalls.
      seq_mode = 1; iv_mode = 0; rdy_mode = 0; lock_mode = 0;
      run_blocks(1);

      // Backpressure pattern 1,0,0,1 on random data.
      seq_mode = 0; rdy_mode = 1;
      run_blocks(1);

      // Input gaps and random ready.
      iv_mode = 1; rdy_mode = 2;
      run_blocks(1);

      // Input held active with all-ones during drain.
      iv_mode = 0; lock_mode = 1;
      run_blocks(1);
      lock_mode = 0;

      // Reset in the middle of a drain, then a full block.
      iv_mode = 0; rdy_mode = 0;
      for (int cyc = 0; cyc < 1000; cyc++) begin
         @(negedge clk);
         if (out_cnt_m >= 20) break;
      end
      chk("reached_20_outputs", out_cnt_m >= 20, 1);
      do_reset(1);
      iv_mode = 1; rdy_mode = 2;
      run_blocks(1);

      // Three back-to-back blocks from a clean reset.
      do_reset(2);
      iv_mode = 0; rdy_mode = 0;
      run_blocks(3);

      repeat (3) @(negedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not complete, compared %0d", n_cmp);
      $fatal(1, "watchdog");
   end

endmodule
